// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared definitions for the MMIO responder register block
// Contents: register offsets, responder FSM state encoding, STATUS field positions
//           and a helper that assembles the STATUS word.
package mmio_pkg;

   // Register offsets relative to BASE_ADDR (byte offsets, word aligned)
   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_INDATA = 4'h8;
   localparam logic [3:0] OFF_CYCLES = 4'hC;

   // Responder FSM encoding
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   // STATUS register field positions
   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_CNT_LSB   = 2;
   localparam int STAT_CNT_MSB   = 7;
   localparam int STAT_OVF_BIT   = 8;

   // STATUS write bit that clears the sticky overflow flag
   localparam int STAT_OVF_CLR_BIT = 8;

   function automatic logic [31:0] pack_status(input logic       empty,
                                               input logic       full,
                                               input logic [5:0] count,
                                               input logic       ovf);
      logic [31:0] s;
      s                             = '0;
      s[STAT_EMPTY_BIT]             = empty;
      s[STAT_FULL_BIT]              = full;
      s[STAT_CNT_MSB:STAT_CNT_LSB]  = count;
      s[STAT_OVF_BIT]               = ovf;
      return s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop, full/empty and occupancy count
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   push, push_data     write request and data (ignored when full unless popping)
//   pop                 read request (ignored when empty)
//   pop_data            head entry, 0 when empty
//   full, empty, count  occupancy status
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // A pop frees a slot in the same cycle, so a push into a full FIFO is
   // accepted when it coincides with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head is forced to 0 when empty so the output never shows stale storage.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - memory-mapped register responder with TX FIFO, input port and cycle counter
// Ports:
//   clk, rst                               rising-edge clock, synchronous active-high reset
//   req_valid, req_we, req_addr, req_wdata request (held by requester until rsp_valid)
//   rsp_valid, rsp_rdata, rsp_err          one-cycle response, data/error zero outside it
//   io_out_data, io_out_valid, io_out_ready TX FIFO head stream to the device
//   io_in_data                             external word sampled by INDATA loads
// Register map (byte offsets from BASE_ADDR):
//   0x0 TXDATA  store pushes to TX FIFO, load returns 0
//   0x4 STATUS  {overflow[8], count[7:2], full[1], empty[0]}; store wdata[8]=1 clears overflow
//   0x8 INDATA  load returns io_in_data captured at the accepting edge
//   0xC CYCLES  free-running counter, store reloads it
module mmio_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFF0,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] io_out_data,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   input  logic [31:0] io_in_data
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   logic [31:0]       offset;
   logic [3:0]        reg_sel;
   logic              addr_ok;
   logic              accept;
   logic              wr_tx;
   logic              wr_ovf_clr;
   logic              wr_cycles;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              overflow;
   logic [31:0]       cycles;
   logic [31:0]       rd_data;

   // Subtracting the base turns the window check into "upper offset bits are
   // zero", which also handles a block sitting at the very top of memory.
   assign offset  = req_addr - BASE_ADDR;
   assign reg_sel = offset[3:0];
   assign addr_ok = (offset[31:4] == '0) && (req_addr[1:0] == 2'b00);

   assign accept     = (state == ST_IDLE) && req_valid;
   assign wr_tx      = accept && addr_ok && req_we && (reg_sel == OFF_TXDATA);
   assign wr_ovf_clr = accept && addr_ok && req_we && (reg_sel == OFF_STATUS)
                       && req_wdata[STAT_OVF_CLR_BIT];
   assign wr_cycles  = accept && addr_ok && req_we && (reg_sel == OFF_CYCLES);

   assign io_out_valid = !fifo_empty;
   assign fifo_pop     = io_out_valid && io_out_ready;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_tx),
      .push_data (req_wdata),
      .pop       (fifo_pop),
      .pop_data  (io_out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Sticky overflow: a push is only lost when full and no pop frees a slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_tx && fifo_full && !fifo_pop) begin
         overflow <= 1'b1;
      end else if (wr_ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycles <= '0;
      end else if (wr_cycles) begin
         cycles <= req_wdata;
      end else begin
         cycles <= cycles + 32'd1;
      end
   end

   // Load data reflects register state just before the accepting edge.
   always_comb begin
      rd_data = '0;
      case (reg_sel)
         OFF_STATUS: rd_data = pack_status(fifo_empty, fifo_full, 6'(fifo_count), overflow);
         OFF_INDATA: rd_data = io_in_data;
         OFF_CYCLES: rd_data = cycles;
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !addr_ok;
                  rsp_rdata <= (addr_ok && !req_we) ? rd_data : '0;
               end else begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - self-checking bench for mmio_responder
module tb_mmio_responder;

   localparam logic [31:0] BASE = 32'hFFFF_FFF0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] io_out_data;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [31:0] io_in_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mmio_responder #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .io_out_data  (io_out_data),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_in_data   (io_in_data)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] in_data;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic        exp_ovalid;
      logic [31:0] exp_odata;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One request: drive at negedge, accept on the next rising edge, sample
   // the response in the RESP cycle, release, then let RESP return to IDLE.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] indata, input logic ready,
                      output logic v, output logic e, output logic [31:0] d,
                      output logic ov, output logic [31:0] od);
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wdata;
      io_in_data   = indata;
      io_out_ready = ready;
      @(posedge clk);
      @(negedge clk);
      v  = rsp_valid;
      e  = rsp_err;
      d  = rsp_rdata;
      ov = io_out_valid;
      od = io_out_data;
      req_valid    = 1'b0;
      io_out_ready = 1'b0;
      @(posedge clk);
   endtask

   task automatic load_status(input string name, input logic [31:0] exp);
      logic v, e, ov;
      logic [31:0] d, od;
      txn(1'b0, BASE + 32'h4, 32'h0, 32'h0, 1'b0, v, e, d, ov, od);
      chk({name, "_valid"}, 32'(v), 32'd1);
      chk({name, "_err"}, 32'(e), 32'd0);
      chk(name, d, exp);
   endtask

   task automatic drain(input string name, input logic [31:0] exp_q [$]);
      foreach (exp_q[i]) begin
         @(negedge clk);
         chk({name, "_ovalid"}, 32'(io_out_valid), 32'd1);
         chk({name, "_odata"}, io_out_data, exp_q[i]);
         io_out_ready = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      io_out_ready = 1'b0;
      chk({name, "_empty"}, 32'(io_out_valid), 32'd0);
   endtask

   function automatic vec_t mk(input string n, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] ind,
                               input logic err, input logic [31:0] rd,
                               input logic ov, input logic [31:0] od);
      vec_t r;
      r.name = n; r.we = we; r.addr = addr; r.wdata = wdata; r.in_data = ind;
      r.exp_err = err; r.exp_rdata = rd; r.exp_ovalid = ov; r.exp_odata = od;
      return r;
   endfunction

   initial begin
      logic v, e, ov;
      logic [31:0] d, od;
      logic [31:0] q [$];

      // io_out_ready stays low for every table vector, so the head stays 0xA5
      vecs[0]  = mk("tx_a5",        1, BASE + 32'h0,  32'h0000_00A5, 32'h0,         0, 32'h0,         1, 32'hA5);
      vecs[1]  = mk("status_1",     0, BASE + 32'h4,  32'h0,         32'h0,         0, 32'h0000_0004, 1, 32'hA5);
      vecs[2]  = mk("tx_2",         1, BASE + 32'h0,  32'h2,         32'h0,         0, 32'h0,         1, 32'hA5);
      vecs[3]  = mk("tx_3",         1, BASE + 32'h0,  32'h3,         32'h0,         0, 32'h0,         1, 32'hA5);
      vecs[4]  = mk("tx_4",         1, BASE + 32'h0,  32'h4,         32'h0,         0, 32'h0,         1, 32'hA5);
      vecs[5]  = mk("status_full",  0, BASE + 32'h4,  32'h0,         32'h0,         0, 32'h0000_0012, 1, 32'hA5);
      vecs[6]  = mk("tx_5_ovf",     1, BASE + 32'h0,  32'h5,         32'h0,         0, 32'h0,         1, 32'hA5);
      vecs[7]  = mk("status_ovf",   0, BASE + 32'h4,  32'h0,         32'h0,         0, 32'h0000_0112, 1, 32'hA5);
      vecs[8]  = mk("ovf_clear",    1, BASE + 32'h4,  32'h0000_0100, 32'h0,         0, 32'h0,         1, 32'hA5);
      vecs[9]  = mk("status_clr",   0, BASE + 32'h4,  32'h0,         32'h0,         0, 32'h0000_0012, 1, 32'hA5);
      vecs[10] = mk("ld_out_range", 0, BASE + 32'h10, 32'h0,         32'h0,         1, 32'h0,         1, 32'hA5);
      vecs[11] = mk("ld_misalign",  0, BASE + 32'h2,  32'h0,         32'h0,         1, 32'h0,         1, 32'hA5);
      vecs[12] = mk("st_out_range", 1, BASE + 32'h10, 32'h77,        32'h0,         1, 32'h0,         1, 32'hA5);
      vecs[13] = mk("status_same",  0, BASE + 32'h4,  32'h0,         32'h0,         0, 32'h0000_0012, 1, 32'hA5);
      vecs[14] = mk("ld_txdata",    0, BASE + 32'h0,  32'h0,         32'h0,         0, 32'h0,         1, 32'hA5);
      vecs[15] = mk("ld_indata",    0, BASE + 32'h8,  32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1, 32'hA5);
      vecs[16] = mk("st_cycles",    1, BASE + 32'hC,  32'hFFFF_FFFE, 32'h0,         0, 32'h0,         1, 32'hA5);
      // Loads accepted 2 and 4 edges after the store see 1 and 3 elapsed cycles
      vecs[17] = mk("ld_cycles_a",  0, BASE + 32'hC,  32'h0,         32'h0,         0, 32'hFFFF_FFFF, 1, 32'hA5);

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      io_out_ready = 1'b0; io_in_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   32'(rsp_err), 32'd0);
      chk("rst_ovalid",    32'(io_out_valid), 32'd0);
      chk("rst_odata",     io_out_data, 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].in_data, 1'b0, v, e, d, ov, od);
         chk({vecs[i].name, "_valid"},  32'(v),  32'd1);
         chk({vecs[i].name, "_err"},    32'(e),  32'(vecs[i].exp_err));
         chk({vecs[i].name, "_rdata"},  d,       vecs[i].exp_rdata);
         chk({vecs[i].name, "_ovalid"}, 32'(ov), 32'(vecs[i].exp_ovalid));
         chk({vecs[i].name, "_odata"},  od,      vecs[i].exp_odata);
      end
      txn(1'b0, BASE + 32'hC, 32'h0, 32'h0, 1'b0, v, e, d, ov, od);
      chk("ld_cycles_wrap", d, 32'h0000_0001);

      // Drain: dropped word 5 must not appear
      q = '{32'hA5, 32'h2, 32'h3, 32'h4};
      drain("drain1", q);
      // Pop while empty has no effect
      @(negedge clk);
      io_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      io_out_ready = 1'b0;
      load_status("status_empty", 32'h0000_0001);

      // Push into a full FIFO while the sink pops on the same edge
      for (int k = 0; k < 4; k++) begin
         txn(1'b1, BASE, 32'h11 + 32'(k), 32'h0, 1'b0, v, e, d, ov, od);
      end
      txn(1'b1, BASE, 32'h15, 32'h0, 1'b1, v, e, d, ov, od);
      chk("full_pushpop_err", 32'(e), 32'd0);
      chk("full_pushpop_head", od, 32'h12);
      load_status("status_pushpop", 32'h0000_0012);

      // Reset in the RESP cycle of an INDATA load, with a store held on the bus
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'h8; io_in_data = 32'h1234;
      @(posedge clk);
      @(negedge clk);
      chk("indata_pre_rst_valid", 32'(rsp_valid), 32'd1);
      chk("indata_pre_rst_rdata", rsp_rdata, 32'h1234);
      rst = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'h99; io_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0; io_out_ready = 1'b0;
      chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_resp_rdata", rsp_rdata, 32'd0);
      chk("rst_resp_ovalid", 32'(io_out_valid), 32'd0);
      load_status("status_after_rst", 32'h0000_0001);
      txn(1'b0, BASE + 32'hC, 32'h0, 32'h0, 1'b0, v, e, d, ov, od);
      chk("cycles_after_rst_small", 32'(d < 32'd16), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
